// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the scoreboarded register file.
// Default geometry and the per-address retire counter.
package reg_file_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int PEND_W_DEF = 2;

    typedef logic [XLEN_DEF-1:0]          word_t;
    typedef logic [$clog2(NREGS_DEF)-1:0] addr_t;

    // Addresses are widened to 8 bits so one helper serves any NREGS <= 256.
    function automatic logic [1:0] retire_cnt(
        input logic [1:0] en,
        input logic [7:0] wa0,
        input logic [7:0] wa1,
        input logic [7:0] a
    );
        logic [1:0] n;
        n = '0;
        if (a != '0) begin
            if (en[0] && wa0 == a) n = n + 2'd1;
            if (en[1] && wa1 == a) n = n + 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Read, write-back and issue bus of the scoreboarded register file.
// master = pipeline side, slave = register file.
interface reg_file_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [1:0]          wr_en;
    logic [2*AW-1:0]     wr_addr;
    logic [2*XLEN-1:0]   wr_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_addr;
    logic                iss_ready;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        output iss_valid, iss_addr,
        input  rd_data, rd_busy, iss_ready
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  iss_valid, iss_addr,
        output rd_data, rd_busy, iss_ready
    );

endinterface

// File: rtl/reg_file_sb_pend_ctr.sv
// Saturating pending-write counter for one architectural register.
// Retires are applied (floored at 0) before the issue increment.
module pend_ctr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic [1:0]   dec,
    output logic [W-1:0] count,
    output logic [W-1:0] after_dec
);
    localparam int WE = W + 1;
    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W:0]   c_ext;
    logic [W:0]   d_ext;

    assign c_ext = {1'b0, cnt_q};
    assign d_ext = WE'(dec);

    always_comb begin
        after_dec = '0;
        if (c_ext > d_ext) after_dec = W'(c_ext - d_ext);
        cnt_d = after_dec;
        if (inc && after_dec != MAX) cnt_d = after_dec + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write-back bypass and
// per-register pending-write scoreboard; x0 is hardwired zero.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int PEND_W = PEND_W_DEF
) (
    input logic         clk,
    input logic         rst_n,
    reg_file_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [XLEN-1:0]   mem_q [NREGS];
    logic [XLEN-1:0]   mem_d [NREGS];
    logic [PEND_W-1:0] cnt   [NREGS];
    logic [PEND_W-1:0] aft   [NREGS];
    logic [1:0]        ret   [NREGS];
    logic [AW-1:0]     wa    [2];
    logic [XLEN-1:0]   wd    [2];
    logic              iss_rdy;

    assign wa[0] = bus.wr_addr[0  +: AW];
    assign wa[1] = bus.wr_addr[AW +: AW];
    assign wd[0] = bus.wr_data[0    +: XLEN];
    assign wd[1] = bus.wr_data[XLEN +: XLEN];

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < 2; p++) begin
            if (bus.wr_en[p] && wa[p] != '0) mem_d[wa[p]] = wd[p];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign cnt[0] = '0;
    assign aft[0] = '0;

    for (genvar r = 0; r < NREGS; r++) begin : g_ret
        assign ret[r] = retire_cnt(bus.wr_en, 8'(wa[0]),
                                   8'(wa[1]), 8'(r));
    end

    for (genvar r = 1; r < NREGS; r++) begin : g_ctr
        logic inc;
        assign inc = bus.iss_valid && iss_rdy &&
                     bus.iss_addr == AW'(r);
        pend_ctr #(.W(PEND_W)) u_ctr (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc),
            .dec       (ret[r]),
            .count     (cnt[r]),
            .after_dec (aft[r])
        );
    end

    // A full counter still accepts an issue if a retire lands this cycle.
    assign iss_rdy = (bus.iss_addr == '0) ||
                     (cnt[bus.iss_addr] != PEND_MAX) ||
                     (ret[bus.iss_addr] != 2'd0);
    assign bus.iss_ready = iss_rdy;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;
        assign ra = bus.rd_addr[k*AW +: AW];
        always_comb begin
            rdat = mem_q[ra];
            if (bus.wr_en[0] && wa[0] == ra) rdat = wd[0];
            if (bus.wr_en[1] && wa[1] == ra) rdat = wd[1];
            if (ra == '0) rdat = '0;
        end
        assign bus.rd_data[k*XLEN +: XLEN] = rdat;
        assign bus.rd_busy[k] = (aft[ra] != '0);
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed cases then random traffic,
// expectations from an array-based model of the register-file rules.
module tb_reg_file_sb;
    import reg_file_pkg::*;

    localparam int PMAX = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();

    reg_file_sb #(
        .XLEN(32), .NREGS(32), .NRD(2), .PEND_W(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic        rdy;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    word_t       m_reg [32];
    int          m_cnt [32];
    logic [1:0]  s_en;
    int          s_wa [2];
    logic [31:0] s_wd [2];

    function automatic int ret_to(int a);
        int n;
        n = 0;
        if (a != 0) begin
            for (int p = 0; p < 2; p++)
                if (s_en[p] && s_wa[p] == a) n++;
        end
        return n;
    endfunction

    function automatic int after(int a);
        int v;
        v = m_cnt[a] - ret_to(a);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic logic [31:0] exp_rd(int a);
        if (a == 0) return 32'h0;
        if (s_en[1] && s_wa[1] == a) return s_wd[1];
        if (s_en[0] && s_wa[0] == a) return s_wd[0];
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(int a);
        return (a != 0) && (after(a) > 0);
    endfunction

    function automatic logic exp_rdy(int a);
        return (a == 0) || (after(a) < PMAX);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = '0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic chk(string nm, int c, logic [31:0] act,
                       logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h",
                     nm, c, act, exp);
        end
    endtask

    task automatic step(
        input logic [1:0]  en,
        input int          wa0,
        input int          wa1,
        input logic [31:0] wd0,
        input logic [31:0] wd1,
        input logic        iv,
        input int          ia,
        input int          ra0,
        input int          ra1,
        input bit          rst
    );
        exp_t e;
        logic acc;
        s_en = en;
        s_wa[0] = wa0;
        s_wa[1] = wa1;
        s_wd[0] = wd0;
        s_wd[1] = wd1;
        bus.wr_en     = en;
        bus.wr_addr   = {5'(wa1), 5'(wa0)};
        bus.wr_data   = {wd1, wd0};
        bus.iss_valid = iv;
        bus.iss_addr  = 5'(ia);
        bus.rd_addr   = {5'(ra1), 5'(ra0)};
        acc = iv && exp_rdy(ia);
        if (rst) begin
            rst_n = 1'b0;
        end else begin
            e.cyc  = cyc;
            e.d0   = exp_rd(ra0);
            e.d1   = exp_rd(ra1);
            e.busy = {exp_busy(ra1), exp_busy(ra0)};
            e.rdy  = exp_rdy(ia);
            q.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            for (int a = 1; a < 32; a++) m_cnt[a] = after(a);
            for (int p = 0; p < 2; p++)
                if (en[p] && s_wa[p] != 0) m_reg[s_wa[p]] = s_wd[p];
            if (acc && ia != 0) m_cnt[ia]++;
        end
        #1;
        if (rst) rst_n = 1'b1;
        cyc++;
    endtask

    task automatic rd(int ra0, int ra1, int ia);
        step(2'b00, 0, 0, 0, 0, 1'b0, ia, ra0, ra1, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_data0", e.cyc, bus.rd_data[31:0], e.d0);
                chk("rd_data1", e.cyc, bus.rd_data[63:32], e.d1);
                chk("rd_busy", e.cyc, 32'(bus.rd_busy), 32'(e.busy));
                chk("iss_ready", e.cyc, 32'(bus.iss_ready), 32'(e.rdy));
            end
        end
    end

    initial begin : driver
        logic [1:0] en;
        model_clear();
        s_en = '0;
        bus.wr_en = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.iss_valid = 1'b0;
        bus.iss_addr = '0;
        bus.rd_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) rd(i, i + 16, i);

        step(2'b01, 5, 0, 32'h1234, 0, 1'b1, 5, 5, 0, 1'b1);
        rd(5, 0, 5);

        step(2'b01, 5, 0, 32'hDEADBEEF, 0, 1'b0, 0, 5, 0, 1'b0);
        rd(5, 5, 0);
        step(2'b01, 0, 0, 32'h1, 0, 1'b0, 0, 0, 5, 1'b0);
        rd(0, 0, 0);

        step(2'b11, 7, 7, 32'h11, 32'h22, 1'b0, 0, 7, 7, 1'b0);
        rd(7, 0, 7);

        repeat (3) step(2'b00, 0, 0, 0, 0, 1'b1, 3, 3, 4, 1'b0);
        rd(3, 4, 3);
        rd(3, 4, 4);
        step(2'b01, 3, 0, 32'h33, 0, 1'b0, 3, 3, 0, 1'b0);
        rd(3, 0, 3);

        step(2'b00, 0, 0, 0, 0, 1'b1, 9, 9, 0, 1'b0);
        step(2'b01, 9, 0, 32'h99, 0, 1'b1, 9, 9, 0, 1'b0);
        rd(9, 0, 9);
        step(2'b10, 0, 9, 0, 32'h55, 1'b0, 9, 9, 0, 1'b0);
        rd(9, 0, 9);

        step(2'b01, 12, 0, 32'hA5, 0, 1'b0, 12, 12, 0, 1'b0);
        rd(12, 0, 12);

        for (int n = 0; n < 600; n++) begin
            en = 2'($urandom);
            step(en, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom, $urandom, 1'($urandom),
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 31),
                 ($urandom_range(0, 199) == 0));
        end

        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
